// File: rtl/breath_sequencer_if.sv
// ============================================================================
// Module      : breath_sequencer_if
// Description : Enable, mode-request handshake and status bundle of the
//               breathing-LED sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface breath_sequencer_if;
    logic       enable;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    logic [7:0] led_select;
    logic       period_tick;
    logic [1:0] mode;
    logic       running;

    modport master (
        output enable, mode_req_valid, mode_req,
        input  mode_req_ready, led_select, period_tick, mode, running
    );

    modport slave (
        input  enable, mode_req_valid, mode_req,
        output mode_req_ready, led_select, period_tick, mode, running
    );
endinterface

`default_nettype wire

// File: rtl/breath_sequencer.sv
// ============================================================================
// Module      : breath_sequencer
// Description : Chooses which LED the breathing driver works on and advances it
//               only on breath-period boundaries. Define BREATH_SEQ_RANDOM_EN
//               to make mode 3 an LFSR-driven random walk (otherwise: hold).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module breath_sequencer #(
    parameter int PERIOD_CYCLES = 600,
    parameter int NUM_LEDS      = 8,
    parameter int DWELL_PERIODS = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    breath_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int DW_W  = $clog2(DWELL_PERIODS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL_PERIODS - 1);

    localparam logic [1:0] MODE_FWD  = 2'd0;
    localparam logic [1:0] MODE_REV  = 2'd1;
    localparam logic [1:0] MODE_PING = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_up_q, dir_up_d;
    logic [1:0]       mode_q, mode_d;
    logic             pending_q, pending_d;
    logic [1:0]       pend_mode_q, pend_mode_d;
    logic             tick_q;
    logic             accept, apply, advance;

`ifdef BREATH_SEQ_RANDOM_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Candidate comes from the freshly stepped LFSR; a collision bumps by one
    // so the lit LED is guaranteed to move.
    function automatic logic [IDX_W-1:0] rand_pick(input logic [7:0] l,
                                                   input logic [IDX_W-1:0] cur);
        int unsigned      v;
        logic [IDX_W-1:0] cand;
        v    = 32'(l[2:0]) % NUM_LEDS;
        cand = IDX_W'(v);
        if (cand == cur)
            cand = (cur == LAST_IDX) ? '0 : cur + 1'b1;
        return cand;
    endfunction
`endif

    always_comb begin
        accept  = bus.mode_req_valid && !pending_q;
        // Leaving RUN or sitting in IDLE applies a pending mode immediately.
        apply   = pending_q && ((state_q == IDLE) || !bus.enable || tick_q);
        advance = (state_q == RUN) && bus.enable && tick_q &&
                  (dwell_cnt_q == LAST_DWELL) && !apply;

        state_d      = bus.enable ? RUN : IDLE;
        period_cnt_d = '0;
        if ((state_q == RUN) && bus.enable)
            period_cnt_d = (period_cnt_q == LAST_CNT) ? '0 : period_cnt_q + 1'b1;

        dwell_cnt_d = dwell_cnt_q;
        if (apply || !bus.enable)
            dwell_cnt_d = '0;
        else if ((state_q == RUN) && tick_q)
            dwell_cnt_d = (dwell_cnt_q == LAST_DWELL) ? '0 : dwell_cnt_q + 1'b1;

        idx_d       = idx_q;
        dir_up_d    = dir_up_q;
        mode_d      = mode_q;
        pending_d   = pending_q;
        pend_mode_d = pend_mode_q;
`ifdef BREATH_SEQ_RANDOM_EN
        lfsr_d      = lfsr_q;
`endif

        if (accept) begin
            pending_d   = 1'b1;
            pend_mode_d = bus.mode_req;
        end

        if (apply) begin
            pending_d = 1'b0;
            mode_d    = pend_mode_q;
            dir_up_d  = 1'b1;
            idx_d     = (pend_mode_q == MODE_REV) ? LAST_IDX : '0;
        end else if (advance) begin
            case (mode_q)
                MODE_FWD: idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                MODE_REV: idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
                MODE_PING: begin
                    if (dir_up_q) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d    = idx_q - 1'b1;
                            dir_up_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        if (idx_q == '0) begin
                            idx_d    = idx_q + 1'b1;
                            dir_up_d = 1'b1;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                end
                default: begin
`ifdef BREATH_SEQ_RANDOM_EN
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    idx_d  = rand_pick(lfsr_d, idx_q);
`else
                    idx_d  = idx_q;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            idx_q        <= '0;
            dir_up_q     <= 1'b1;
            mode_q       <= MODE_FWD;
            pending_q    <= 1'b0;
            pend_mode_q  <= MODE_FWD;
            tick_q       <= 1'b0;
`ifdef BREATH_SEQ_RANDOM_EN
            lfsr_q       <= 8'hA5;
`endif
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            idx_q        <= idx_d;
            dir_up_q     <= dir_up_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            pend_mode_q  <= pend_mode_d;
            // High for exactly the cycle in which the counter sits on its last value.
            tick_q       <= (state_d == RUN) && (period_cnt_d == LAST_CNT);
`ifdef BREATH_SEQ_RANDOM_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign bus.mode_req_ready = !pending_q;
    assign bus.led_select     = 8'(idx_q);
    assign bus.period_tick    = tick_q;
    assign bus.mode           = mode_q;
    assign bus.running        = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_breath_sequencer.sv
// ============================================================================
// Module      : tb_breath_sequencer
// Description : Drives two sequencers (dwell 1 and dwell 3) with directed and
//               random stimulus and compares them with a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_breath_sequencer;
    localparam int P = 4;
    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vld;
    logic [1:0] req;

    int n_pass;
    int n_total;

    breath_sequencer_if bus1 ();
    breath_sequencer_if bus3 ();

    assign bus1.enable         = en;
    assign bus1.mode_req_valid = vld;
    assign bus1.mode_req       = req;
    assign bus3.enable         = en;
    assign bus3.mode_req_valid = vld;
    assign bus3.mode_req       = req;

    breath_sequencer #(.PERIOD_CYCLES(P), .NUM_LEDS(N), .DWELL_PERIODS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    breath_sequencer #(.PERIOD_CYCLES(P), .NUM_LEDS(N), .DWELL_PERIODS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: index rules written as modular arithmetic, ping-pong
    // as a position on a 2N-2 cycle folded onto 0..N-1.
    typedef struct {
        int dwell_periods;
        bit run;
        bit tick;
        bit pend;
        bit rnd;
        bit adv_rnd;
        int cnt;
        int dwell;
        int idx;
        int pos;
        int mode;
        int pmode;
        int last_led;
    } model_t;

    model_t m [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].dwell_periods = (k == 0) ? 1 : 3;
            m[k].run = 0; m[k].tick = 0; m[k].pend = 0; m[k].rnd = 0; m[k].adv_rnd = 0;
            m[k].cnt = 0; m[k].dwell = 0; m[k].idx = 0; m[k].pos = 0;
            m[k].mode = 0; m[k].pmode = 0; m[k].last_led = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit v, input int r);
        bit acc;
        bit app;
        bit adv;
        for (int k = 0; k < 2; k++) begin
            acc = v && !m[k].pend;
            app = m[k].pend && (!m[k].run || !e || m[k].tick);
            adv = m[k].run && e && m[k].tick && !app && (m[k].dwell == m[k].dwell_periods - 1);
            m[k].adv_rnd = 0;
            if (app) begin
                m[k].mode = m[k].pmode;
                m[k].pos  = 0;
                m[k].rnd  = 0;
                m[k].idx  = (m[k].pmode == 1) ? N - 1 : 0;
                m[k].pend = 0;
            end else if (adv) begin
                case (m[k].mode)
                    0: m[k].idx = (m[k].idx + 1) % N;
                    1: m[k].idx = (m[k].idx + N - 1) % N;
                    2: begin
                        m[k].pos = (m[k].pos + 1) % (2 * N - 2);
                        m[k].idx = (m[k].pos < N) ? m[k].pos : 2 * N - 2 - m[k].pos;
                    end
                    default: begin
`ifdef BREATH_SEQ_RANDOM_EN
                        m[k].rnd     = 1;
                        m[k].adv_rnd = 1;
`endif
                    end
                endcase
            end
            if (acc) begin
                m[k].pend  = 1;
                m[k].pmode = r;
            end
            if (app || !e)
                m[k].dwell = 0;
            else if (m[k].run && m[k].tick)
                m[k].dwell = (m[k].dwell + 1) % m[k].dwell_periods;
            m[k].cnt  = (m[k].run && e) ? (m[k].cnt + 1) % P : 0;
            m[k].run  = e;
            m[k].tick = e && (m[k].cnt == P - 1);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic compare_all();
        logic [7:0] led;
        for (int k = 0; k < 2; k++) begin
            led = (k == 0) ? bus1.led_select : bus3.led_select;
            if (m[k].rnd) begin
                if (m[k].adv_rnd) begin
                    check($sformatf("dut%0d rnd_changed t=%0t", k, $time),
                          8'(led != 8'(m[k].last_led)), 8'd1);
                    check($sformatf("dut%0d rnd_range t=%0t", k, $time),
                          8'(led < 8'(N)), 8'd1);
                end
            end else begin
                check($sformatf("dut%0d led_select t=%0t", k, $time), led, 8'(m[k].idx));
            end
            m[k].last_led = int'(led);
            check($sformatf("dut%0d mode t=%0t", k, $time),
                  8'((k == 0) ? bus1.mode : bus3.mode), 8'(m[k].mode));
            check($sformatf("dut%0d period_tick t=%0t", k, $time),
                  8'((k == 0) ? bus1.period_tick : bus3.period_tick), 8'(m[k].tick));
            check($sformatf("dut%0d running t=%0t", k, $time),
                  8'((k == 0) ? bus1.running : bus3.running), 8'(m[k].run));
            check($sformatf("dut%0d ready t=%0t", k, $time),
                  8'((k == 0) ? bus1.mode_req_ready : bus3.mode_req_ready), 8'(!m[k].pend));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(en, vld, int'(req));
        #1;
        compare_all();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        en      = 1'b0;
        vld     = 1'b0;
        req     = 2'd0;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // forward rotation
        en = 1'b1;
        repeat (36) cycle();

        // reverse requested mid-period
        vld = 1'b1; req = 2'd1;
        cycle();
        vld = 1'b0;
        repeat (40) cycle();

        // ping-pong
        vld = 1'b1; req = 2'd2;
        cycle();
        vld = 1'b0;
        repeat (70) cycle();

        // enable drop and re-enable
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        repeat (10) cycle();

        // request accepted in a tick cycle
        for (int i = 0; i < 16; i++) begin
            if (m[0].tick) break;
            cycle();
        end
        check("tick_found", 8'(m[0].tick), 8'd1);
        vld = 1'b1; req = 2'd0;
        cycle();
        vld = 1'b0;
        repeat (12) cycle();

        // enable falls while a request is pending
        vld = 1'b1; req = 2'd1;
        cycle();
        vld = 1'b0; en = 1'b0;
        repeat (2) cycle();
        en = 1'b1;
        repeat (8) cycle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom % 10) != 0;
            vld = ($urandom % 6) == 0;
`ifdef BREATH_SEQ_RANDOM_EN
            req = 2'($urandom % 3);
`else
            req = 2'($urandom % 4);
`endif
            cycle();
        end

        // mode 3 held long enough for well over 20 ticks
        en = 1'b1; vld = 1'b1; req = 2'd3;
        cycle();
        vld = 1'b0;
        repeat (100) cycle();

        // back to forward, then asynchronous reset while on LED 5 mid-period
        vld = 1'b1; req = 2'd0;
        cycle();
        vld = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m[0].idx == 5 && m[0].cnt == 1 && !m[0].pend) break;
            cycle();
        end
        check("pre_reset_led5", bus1.led_select, 8'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_led", bus1.led_select, 8'd0);
        check("async_mode", 8'(bus1.mode), 8'd0);
        check("async_ready", 8'(bus1.mode_req_ready), 8'd1);
        check("async_running", 8'(bus1.running), 8'd0);
        check("async_led_d3", bus3.led_select, 8'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
